// File: rtl/mdu_seq.sv
// mdu_seq: multi-cycle MULT/MULTU/DIV/DIVU sequencer for the HILO path.
// Operands are reduced to magnitudes, a 32-step shift-add or restoring-divide
// loop runs on a shared 2*WIDTH accumulator, and the sign is restored in FIX.
//
// state | meaning
// IDLE  | waiting for start; stalls the pipe in the accepting cycle
// CALC  | one multiply/divide iteration per clock
// FIX   | two's-complement sign correction, loads hilores
// DONE  | hilores valid, one-cycle HILO write strobe
module mdu_seq #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [1:0]           op,
    input  logic [WIDTH-1:0]     srca,
    input  logic [WIDTH-1:0]     srcb,
    input  logic                 cancel,
    output logic                 stall,
    output logic                 busy,
    output logic                 done,
    output logic                 hilowe,
    output logic [2*WIDTH-1:0]   hilores
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t               state, state_nxt;
    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   acc;       // multiply: {hi,lo} product; divide: {rem,quot}
    logic [WIDTH-1:0]     opnd;      // multiplicand or divisor magnitude
    logic                 is_mul;
    logic                 neg_lo;    // negate product (multiply) or quotient (divide)
    logic                 neg_hi;    // negate remainder (divide only)

    logic                 op_div, op_signed, div_zero, accept, last_iter;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH:0]       mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0]   mul_next, div_next, fix_val;
    logic [WIDTH-1:0]     rem_fix, quot_fix;

    assign op_div    = op[1];
    assign op_signed = ~op[0];
    assign a_mag     = (op_signed && srca[WIDTH-1]) ? -srca : srca;
    assign b_mag     = (op_signed && srcb[WIDTH-1]) ? -srcb : srcb;
    assign div_zero  = op_div && (srcb == '0);
    assign accept    = (state == IDLE) && start && !cancel;
    assign last_iter = (cnt == CW'(WIDTH - 1));

    // One iteration of each algorithm, computed from the current accumulator
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
        mul_next  = acc[0] ? {mul_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd};
        div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        rem_fix   = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        quot_fix  = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        fix_val   = is_mul ? (neg_lo ? -acc : acc) : {rem_fix, quot_fix};
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and status outputs
    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        busy      = (state != IDLE);
        done      = 1'b0;
        hilowe    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    stall     = 1'b1;
                    state_nxt = div_zero ? FIX : CALC;
                end
            end
            CALC: begin
                stall = 1'b1;
                if (cancel)         state_nxt = IDLE;
                else if (last_iter) state_nxt = FIX;
            end
            FIX: begin
                stall     = 1'b1;
                state_nxt = cancel ? IDLE : DONE;
            end
            DONE: begin
                done      = 1'b1;
                hilowe    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, iteration datapath and result register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            acc     <= '0;
            opnd    <= '0;
            is_mul  <= 1'b0;
            neg_lo  <= 1'b0;
            neg_hi  <= 1'b0;
            hilores <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt    <= '0;
                        is_mul <= ~op_div;
                        if (div_zero) begin
                            // Result preloaded; FIX passes it through uncorrected
                            acc    <= {srca, {WIDTH{1'b1}}};
                            opnd   <= '0;
                            neg_lo <= 1'b0;
                            neg_hi <= 1'b0;
                        end else if (!op_div) begin
                            acc    <= {{WIDTH{1'b0}}, b_mag};
                            opnd   <= a_mag;
                            neg_lo <= op_signed & (srca[WIDTH-1] ^ srcb[WIDTH-1]);
                            neg_hi <= 1'b0;
                        end else begin
                            acc    <= {{WIDTH{1'b0}}, a_mag};
                            opnd   <= b_mag;
                            neg_lo <= op_signed & (srca[WIDTH-1] ^ srcb[WIDTH-1]);
                            neg_hi <= op_signed & srca[WIDTH-1];
                        end
                    end
                end
                CALC: begin
                    if (!cancel) begin
                        acc <= is_mul ? mul_next : div_next;
                        cnt <= cnt + 1'b1;
                    end
                end
                FIX: begin
                    if (!cancel) hilores <= fix_val;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_seq.sv
// Scoreboard bench for mdu_seq: the driver pushes reference results computed
// with plain 64-bit arithmetic; a monitor pops and compares on every hilowe.
module tb_mdu_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] srca = '0;
    logic [31:0] srcb = '0;
    logic        cancel = 1'b0;
    logic        stall, busy, done, hilowe;
    logic [63:0] hilores;

    mdu_seq #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .srca(srca),
        .srcb(srcb), .cancel(cancel), .stall(stall), .busy(busy),
        .done(done), .hilowe(hilowe), .hilores(hilores)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] res;
        int          start_cyc;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [63:0] last_res = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: MIPS HILO semantics with 64-bit arithmetic
    function automatic logic [63:0] ref_res(input logic [1:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
        longint      sa, sbv, q, r;
        logic [63:0] ua, ub, p;
        ua = {32'b0, a};
        ub = {32'b0, b};
        sa = longint'($signed(a));
        sbv = longint'($signed(b));
        case (o)
            2'd0: begin p = sa * sbv; return p; end
            2'd1: begin p = ua * ub; return p; end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (o == 2'd2) begin
                    q = sa / sbv;
                    r = sa % sbv;
                    return {r[31:0], q[31:0]};
                end
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Monitor: every HILO write must match the oldest outstanding request
    always @(negedge clk) begin
        if (hilowe) begin
            if (sb.size() == 0) begin
                chk("unexpected_hilowe", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("hilores", hilores, e.res);
                chk("done_with_hilowe", {63'b0, done}, 64'd1);
                chk("latency", 64'(cyc - e.start_cyc), 64'(e.lat));
            end
        end
    end

    // mode: 0 plain, 1 cancel asserted during DONE, 2 extra start pulse mid-CALC
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int mode);
        exp_t e;
        int   n_stall;
        bit   fin;
        bit   dz;
        dz = o[1] && (b == 32'd0);
        @(negedge clk);
        op = o; srca = a; srcb = b; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        op = 2'($urandom); srca = $urandom; srcb = $urandom;
        e.res = ref_res(o, a, b);
        e.start_cyc = cyc;
        e.lat = dz ? 1 : 33;
        sb.push_back(e);
        n_stall = 0;
        fin = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (stall) n_stall++;
            if (mode == 2 && i == 5) begin
                start = 1'b1; op = 2'($urandom); srca = $urandom; srcb = $urandom;
            end
            if (mode == 2 && i == 6) start = 1'b0;
            if (mode == 1 && done) cancel = 1'b1;
            if (!busy) begin fin = 1; break; end
        end
        cancel = 1'b0;
        start = 1'b0;
        if (!fin) chk("op_timeout", 64'd1, 64'd0);
        chk("stall_cycles", 64'(n_stall), dz ? 64'd1 : 64'd33);
        last_res = e.res;
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        int          r;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_stall", {63'b0, stall}, 64'd0);
        chk("rst_done", {62'b0, done, hilowe}, 64'd0);
        chk("rst_hilores", hilores, 64'd0);
        @(negedge clk);
        reset = 1'b1;

        run_op(2'd0, 32'hFFFF_FFFD, 32'd7, 0);
        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(2'd3, 32'd100, 32'd7, 0);
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(2'd3, 32'h0000_1234, 32'd0, 0);
        run_op(2'd2, 32'hFFFF_FF00, 32'd0, 1);
        run_op(2'd1, 32'd123456, 32'd789, 2);

        // cancel in IDLE overrides start
        @(negedge clk);
        start = 1'b1; cancel = 1'b1; op = 2'd0; srca = 32'd9; srcb = 32'd9;
        #1;
        chk("idle_cancel_stall", {63'b0, stall}, 64'd0);
        @(posedge clk);
        #1;
        start = 1'b0; cancel = 1'b0;
        chk("idle_cancel_busy", {63'b0, busy}, 64'd0);

        // cancel on CALC cycle 10
        @(negedge clk);
        op = 2'd3; srca = 32'd1000; srcb = 32'd7; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(negedge clk);
        chk("calc_stall", {63'b0, stall}, 64'd1);
        cancel = 1'b1;
        @(posedge clk);
        #1;
        cancel = 1'b0;
        chk("cancel_busy", {63'b0, busy}, 64'd0);
        chk("cancel_stall", {63'b0, stall}, 64'd0);
        repeat (40) @(negedge clk);
        chk("cancel_hilores_kept", hilores, last_res);

        // asynchronous reset mid-CALC
        @(negedge clk);
        op = 2'd0; srca = 32'd77; srcb = 32'd55; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_busy", {63'b0, busy}, 64'd0);
        chk("arst_stall", {63'b0, stall}, 64'd0);
        chk("arst_done", {62'b0, done, hilowe}, 64'd0);
        chk("arst_hilores", hilores, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        run_op(2'd1, 32'd3, 32'd5, 0);

        // randomized operations with boundary operands mixed in
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 7);
            ro = 2'($urandom);
            ra = (r == 2) ? 32'h8000_0000 : $urandom;
            rb = (r == 0) ? 32'd0 : (r == 1) ? 32'hFFFF_FFFF : $urandom;
            if (r == 3) rb = 32'($urandom_range(1, 20));
            run_op(ro, ra, rb, 0);
        end

        repeat (3) @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
Multi-cycle multiply/divide sequencer for the MIPS-32 pipeline. It accepts MULT/MULTU/DIV/DIVU from the Execute stage and runs a 32-iteration shift-add or restoring-divide loop. It holds the pipeline stalled while working, then delivers a 64-bit {hi,lo} result with a one-cycle write strobe to the HILO register path. It replaces single-cycle HILO arithmetic in the ALU for these four instructions.

Parameters:
WIDTH, 32, operand width; the iteration count equals WIDTH.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset; all state clears while reset==0
start  input  1  Execute-stage request; sampled only in IDLE
op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
srca  input  WIDTH  rs operand (multiplicand / dividend), forwarded value
srcb  input  WIDTH  rt operand (multiplier / divisor), forwarded value
cancel  input  1  pipeline flush; aborts the operation in flight
stall  output  1  freeze Fetch/Decode/Execute
busy  output  1  state != IDLE
done  output  1  result valid this cycle
hilowe  output  1  HILO write enable, one-cycle pulse
hilores  output  2*WIDTH  {hi,lo} result

Behaviour:
- States: IDLE, CALC, FIX, DONE. A 6-bit iteration counter cnt.
- Reset: state=IDLE, cnt=0, hilores=0. done, hilowe, busy and stall are all 0.
- IDLE, start=1, cancel=0 at edge k:
  - Latch |srca|, |srcb| for signed ops, raw values for unsigned ops.
  - Latch result sign: MULT uses sign(a)^sign(b). DIV uses quotient sign a^b and remainder sign a.
  - cnt=0, go to CALC.
  - Exception: DIV/DIVU with srcb==0 goes straight to FIX and skips CALC.
- CALC: one iteration per edge, then cnt++.
  - Multiply: shift-add on the 64-bit accumulator.
  - Divide: restoring step on the {rem,quot} pair.
  - After the edge where cnt reaches WIDTH-1 → FIX. This is edge k+32.
- FIX, at edge k+33: apply the two's-complement sign correction, load hilores, go to DONE.
  - Multiply: hilores = product.
  - Divide: hi = remainder, lo = quotient.
- DONE: done=1 and hilowe=1 for exactly this cycle. The next edge goes to IDLE.
- Latency: the DONE cycle is the 34th cycle after the start edge. A divide by zero reaches DONE 2 cycles after the start edge.
- stall = (state==IDLE & start & ~cancel) | state==CALC | state==FIX.
  - stall is 0 in DONE, so the owning instruction advances that cycle.
- busy = 1 in CALC, FIX and DONE.
- Divide by zero: hi=srca, lo=0xFFFFFFFF for both DIV and DIVU.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. No trap.
- Sign rules: the quotient truncates toward zero; the remainder takes the dividend's sign.
- cancel:
  - In CALC or FIX: next edge goes to IDLE, no done or hilowe, hilores unchanged.
  - In IDLE: overrides start.
  - In DONE: ignored, and the write still occurs.
- start while busy is ignored. op, srca and srcb may change after the start edge without effect.
- Reset assertion mid-operation returns to IDLE immediately (asynchronous) with no hilowe.
- hilores holds its value until the next FIX.

Test Plan:
- MULT srca=0xFFFFFFFD(-3), srcb=7 → stall high for 33 cycles from start; done and hilowe pulse on cycle 34; hilores=0xFFFFFFFF_FFFFFFEB.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → hilores=0xFFFFFFFE_00000001; hilowe is high exactly one cycle.
- DIV -7(0xFFFFFFF9) / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100 / 7 → lo=0x0000000E, hi=0x00000002.
- DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0. DIVU 0x1234 / 0 → done 2 cycles after start; hi=0x00001234, lo=0xFFFFFFFF.
- Start DIVU, cancel=1 on CALC cycle 10 → IDLE next cycle; no hilowe; prior hilores retained. A second start pulse during CALC is ignored.
- Drive reset=0 mid-CALC → busy, stall, done and hilowe go to 0 immediately and hilores=0. After release, a new MULTU 3×5 gives hilores=0x0000000F.
